// File: rtl/param_counter.sv
// param_counter: up/down counter driven by asynchronous strobes.
//
// Every asynchronous control/data input passes through a SYNC_STAGES-deep
// synchroniser. Rising edges of the synchronised clk_in / load (qualified by
// the synchronised enable) are count / load events; count changes on the clk
// edge after detection, SYNC_STAGES+1 cycles after the pin edge.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   enable    async, gates load and count events
//   clk_in    async count strobe (rising edge = one event)
//   load      async load strobe (rising edge loads in)
//   up_down   async direction, 1 = up
//   sat_mode  async, 1 = saturate at limits, 0 = wrap
//   in        async load value
//   max_val   quasi-static upper limit, used unsynchronised
//   count     registered counter value
//   tc        registered one-cycle terminal-count pulse
//   at_max    registered, count >= max_val
//   at_zero   registered, count == 0
module param_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clk_in,
    input  logic             load,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] ld_sync;
    logic [SYNC_STAGES-1:0] ud_sync;
    logic [SYNC_STAGES-1:0] sat_sync;
    logic [SYNC_STAGES-1:0] valid_sync;
    logic [WIDTH-1:0]       in_sync [SYNC_STAGES];

    logic clk_hist, ld_hist;
    logic clk_armed, ld_armed;
    logic fresh;

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             tc_q, tc_nxt;
    logic             at_max_q, at_zero_q;

    logic en_s, clk_s, ld_s, ud_s, sat_s, valid_s;
    logic [WIDTH-1:0] in_s;
    logic cnt_ev, ld_ev;

    assign en_s    = en_sync[SYNC_STAGES-1];
    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign ld_s    = ld_sync[SYNC_STAGES-1];
    assign ud_s    = ud_sync[SYNC_STAGES-1];
    assign sat_s   = sat_sync[SYNC_STAGES-1];
    assign valid_s = valid_sync[SYNC_STAGES-1];
    assign in_s    = in_sync[SYNC_STAGES-1];

    // Arming waits until the synchroniser holds real pin samples (valid_s),
    // so a strobe already high at reset release is never seen as an edge.
    assign cnt_ev = en_s & clk_s & ~clk_hist & clk_armed;
    assign ld_ev  = en_s & ld_s  & ~ld_hist  & ld_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync    <= '0;
            clk_sync   <= '0;
            ld_sync    <= '0;
            ud_sync    <= '1;
            sat_sync   <= '0;
            valid_sync <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                in_sync[i] <= '0;
            end
            clk_hist  <= 1'b0;
            ld_hist   <= 1'b0;
            clk_armed <= 1'b0;
            ld_armed  <= 1'b0;
        end else begin
            en_sync    <= {en_sync[SYNC_STAGES-2:0],    enable};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0],   clk_in};
            ld_sync    <= {ld_sync[SYNC_STAGES-2:0],    load};
            ud_sync    <= {ud_sync[SYNC_STAGES-2:0],    up_down};
            sat_sync   <= {sat_sync[SYNC_STAGES-2:0],   sat_mode};
            valid_sync <= {valid_sync[SYNC_STAGES-2:0], 1'b1};
            in_sync[0] <= in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                in_sync[i] <= in_sync[i-1];
            end
            clk_hist <= clk_s;
            ld_hist  <= ld_s;
            if (valid_s && !clk_s) clk_armed <= 1'b1;
            if (valid_s && !ld_s)  ld_armed  <= 1'b1;
        end
    end

    always_comb begin
        count_nxt = count_q;
        tc_nxt    = 1'b0;
        if (ld_ev) begin
            count_nxt = (in_s > max_val) ? max_val : in_s;
        end else if (cnt_ev) begin
            if (max_val == '0) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
            end else if (ud_s) begin
                if (count_q < max_val) begin
                    count_nxt = count_q + 1'b1;
                end else begin
                    count_nxt = sat_s ? max_val : '0;
                    tc_nxt    = 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_nxt = sat_s ? '0 : max_val;
                    tc_nxt    = 1'b1;
                end else if (count_q > max_val) begin
                    count_nxt = max_val;
                end else begin
                    count_nxt = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
            fresh     <= 1'b1;
        end else begin
            count_q   <= count_nxt;
            tc_q      <= tc_nxt;
            at_max_q  <= (count_nxt >= max_val);
            at_zero_q <= (count_nxt == '0);
            fresh     <= 1'b0;
        end
    end

    // Until the first clk after reset the count is 0, so at_max reduces to
    // max_val == 0; this avoids a data-dependent asynchronous reset value.
    assign count   = count_q;
    assign tc      = tc_q;
    assign at_zero = at_zero_q;
    assign at_max  = fresh ? (max_val == '0) : at_max_q;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter (WIDTH=8, SYNC_STAGES=2).
// Expected results are pushed to a scoreboard queue when a strobe is driven
// and popped when the counter is due to update, SYNC_STAGES+1 cycles later.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, clk_in, load, up_down, sat_mode;
    logic [7:0] in, max_val;
    logic [7:0] count;
    logic       tc, at_max, at_zero;

    param_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clk_in(clk_in), .load(load),
        .up_down(up_down), .sat_mode(sat_mode), .in(in), .max_val(max_val),
        .count(count), .tc(tc), .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       amax;
        logic       azero;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    bit       m_en, m_up, m_sat;
    bit [7:0] m_max, m_in, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            passed++;
    endtask

    function automatic void model(input bit ld, input bit cnt,
                                  output bit [7:0] nc, output bit ntc);
        nc  = m_cnt;
        ntc = 1'b0;
        if (!m_en) return;
        if (ld) begin
            nc = (m_in > m_max) ? m_max : m_in;
        end else if (cnt) begin
            if (m_max == 8'd0) begin
                nc = 8'd0; ntc = 1'b1;
            end else if (m_up) begin
                if (m_cnt < m_max) nc = m_cnt + 8'd1;
                else begin nc = m_sat ? m_max : 8'd0; ntc = 1'b1; end
            end else begin
                if (m_cnt == 8'd0) begin nc = m_sat ? 8'd0 : m_max; ntc = 1'b1; end
                else if (m_cnt > m_max) nc = m_max;
                else nc = m_cnt - 8'd1;
            end
        end
    endfunction

    task automatic set_cfg(input bit en, input bit up, input bit sat,
                           input bit [7:0] mx, input bit [7:0] iv);
        @(negedge clk);
        enable = en; up_down = up; sat_mode = sat; max_val = mx; in = iv;
        m_en = en; m_up = up; m_sat = sat; m_max = mx; m_in = iv;
        repeat (4) @(negedge clk);
    endtask

    // max_val only changes while the counter is disabled.
    task automatic new_max(input bit [7:0] mx);
        set_cfg(1'b0, m_up, m_sat, m_max, m_in);
        set_cfg(1'b0, m_up, m_sat, mx,    m_in);
        set_cfg(1'b1, m_up, m_sat, mx,    m_in);
    endtask

    task automatic strobe(input string tag, input bit ld, input bit cnt);
        exp_t       e;
        bit [7:0]   nc;
        bit         ntc;
        logic [7:0] old;
        old = m_cnt;
        @(negedge clk);
        clk_in = cnt;
        load   = ld;
        model(ld, cnt, nc, ntc);
        e.cnt   = nc;
        e.tc    = ntc;
        e.amax  = (nc >= m_max);
        e.azero = (nc == 8'd0);
        m_cnt   = nc;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        check({tag, "_latency"}, count, old);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_count"},   count,   e.cnt);
            check({tag, "_tc"},      tc,      e.tc);
            check({tag, "_at_max"},  at_max,  e.amax);
            check({tag, "_at_zero"}, at_zero, e.azero);
        end
        @(negedge clk);
        check({tag, "_tc_drop"}, tc, 1'b0);
        clk_in = 1'b0;
        load   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; clk_in = 1'b0; load = 1'b0;
        up_down = 1'b1; sat_mode = 1'b0; in = 8'd0; max_val = 8'd0;
        m_en = 1'b1; m_up = 1'b1; m_sat = 1'b0; m_max = 8'd0; m_in = 8'd0; m_cnt = 8'd0;

        // Reset state, including at_max following max_val while in reset.
        #23;
        check("rst_count",   count,   8'd0);
        check("rst_tc",      tc,      1'b0);
        check("rst_at_zero", at_zero, 1'b1);
        check("rst_at_max0", at_max,  1'b1);
        max_val = 8'd255; m_max = 8'd255;
        #2;
        check("rst_at_max255", at_max, 1'b0);

        // clk_in already high at reset release must not count.
        clk_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("release_high_count", count, 8'd0);
        check("release_high_tc",    tc,    1'b0);
        clk_in = 1'b0;
        repeat (4) @(negedge clk);

        // Basic up counting.
        set_cfg(1'b1, 1'b1, 1'b0, 8'd255, 8'd0);
        for (int i = 0; i < 3; i++) strobe("up", 1'b0, 1'b1);

        // Wrap at max_val = 9.
        new_max(8'd9);
        set_cfg(1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
        strobe("wrap_load9", 1'b1, 1'b0);
        strobe("wrap_up",    1'b0, 1'b1);
        set_cfg(1'b1, 1'b0, 1'b0, 8'd9, 8'd9);
        strobe("wrap_down",  1'b0, 1'b1);

        // Saturate at max_val = 9.
        set_cfg(1'b1, 1'b1, 1'b1, 8'd9, 8'd9);
        strobe("sat_load9", 1'b1, 1'b0);
        strobe("sat_up",    1'b0, 1'b1);
        set_cfg(1'b1, 1'b0, 1'b1, 8'd9, 8'd0);
        strobe("sat_load0", 1'b1, 1'b0);
        strobe("sat_down",  1'b0, 1'b1);

        // Load clamping and load priority over a same-cycle count.
        new_max(8'h40);
        set_cfg(1'b1, 1'b1, 1'b0, 8'h40, 8'h50);
        strobe("load_clamp", 1'b1, 1'b0);
        set_cfg(1'b1, 1'b1, 1'b0, 8'h40, 8'h10);
        strobe("load_prio",  1'b1, 1'b1);

        // Down with count above a lowered max_val, then max_val = 0.
        new_max(8'd5);
        set_cfg(1'b1, 1'b0, 1'b0, 8'd5, 8'h10);
        strobe("down_above_max", 1'b0, 1'b1);
        new_max(8'd0);
        strobe("max0_down", 1'b0, 1'b1);
        set_cfg(1'b1, 1'b1, 1'b0, 8'd0, 8'h10);
        strobe("max0_up",   1'b0, 1'b1);

        // Disabled: strobes ignored; re-enable with clk_in high is no event.
        new_max(8'd255);
        strobe("en_up", 1'b0, 1'b1);
        set_cfg(1'b0, 1'b1, 1'b0, 8'd255, 8'h10);
        for (int i = 0; i < 5; i++) strobe("disabled", 1'b0, 1'b1);
        @(negedge clk);
        clk_in = 1'b1;
        repeat (4) @(negedge clk);
        set_cfg(1'b1, 1'b1, 1'b0, 8'd255, 8'h10);
        repeat (4) @(negedge clk);
        check("reenable_high_count", count, m_cnt);
        check("reenable_high_tc",    tc,    1'b0);
        clk_in = 1'b0;
        repeat (4) @(negedge clk);

        // Reset one cycle after a clk_in edge aborts the pending event.
        strobe("pre_rst_up", 1'b0, 1'b1);
        @(negedge clk);
        clk_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 8'd0;
        repeat (6) @(negedge clk);
        check("rst_abort_count",   count,   8'd0);
        check("rst_abort_at_zero", at_zero, 1'b1);
        check("rst_abort_tc",      tc,      1'b0);
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
        strobe("post_rst_up", 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and load-data width (2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on every asynchronous input (2..4).
REQ-003 SHALL have port clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  asynchronous; gates load and count events.
REQ-006 SHALL have port clk_in  input  1  asynchronous count strobe; each rising edge is one count event.
REQ-007 SHALL have port load  input  1  asynchronous; each rising edge loads in.
REQ-008 SHALL have port up_down  input  1  asynchronous; 1 = up, 0 = down.
REQ-009 SHALL have port sat_mode  input  1  asynchronous; 1 = saturate at limits, 0 = wrap.
REQ-010 SHALL have port in  input  WIDTH  asynchronous load value.
REQ-011 SHALL have port max_val  input  WIDTH  quasi-static upper limit; used unsynchronised; stable while enable=1.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 SHALL have port at_max  output  1  registered; 1 when count >= max_val.
REQ-015 SHALL have port at_zero  output  1  registered; 1 when count == 0.

Function
REQ-016 SHALL pass enable, clk_in, load, up_down, sat_mode and in through SYNC_STAGES flops each, then one history flop for clk_in and load.
REQ-017 SHALL detect a count event when synchronised clk_in = 1 and its history = 0 and synchronised enable = 1; load events are detected the same way.
REQ-018 SHALL update count on the clk edge after detection: pin edge to count change = SYNC_STAGES+1 clk cycles.
REQ-019 SHALL load the synchronised in (same stage alignment as load), never the raw pin value.
REQ-020 SHALL clamp a load to max_val when the synchronised in > max_val.
REQ-021 SHALL give load priority over a same-cycle count event; the count event is dropped and tc stays 0.
REQ-022 SHALL, up, count < max_val: count+1, tc=0.
REQ-023 SHALL, up, count >= max_val: wrap mode -> 0 and tc=1; saturate mode -> max_val and tc=1.
REQ-024 SHALL, down, 0 < count <= max_val: count-1, tc=0.
REQ-025 SHALL, down, count == 0: wrap mode -> max_val and tc=1; saturate mode -> hold 0 and tc=1.
REQ-026 SHALL, down, count > max_val (max_val lowered): -> max_val, tc=0.
REQ-027 SHALL, with max_val == 0: every count event leaves count at 0 and pulses tc.
REQ-028 SHALL, with synchronised enable = 0: ignore events and hold count, while history flops keep updating so re-enable with clk_in high causes no event.
REQ-029 SHALL hold tc high exactly one clk cycle per terminal event; back-to-back events give back-to-back pulses.
REQ-030 SHALL compute at_max and at_zero from the next count value so they align with count.
REQ-031 SHALL perform all arithmetic modulo 2^WIDTH with no carry output.

Reset
REQ-032 SHALL, while rst=1, force: count=0, tc=0, at_zero=1, at_max=(max_val==0), all sync and history flops 0 except up_down stages = 1.
REQ-033 SHALL, when rst asserts mid-operation, abort any pending detected event; no count or load occurs from edges seen before rst deasserts.
REQ-034 SHALL detect a count event only after clk_in is sampled low at least once following reset release.

Verification
REQ-035 SHALL cover, WIDTH=8, SYNC_STAGES=2, max_val=255: enable=1, up, 3 clk_in pulses -> count 1,2,3, each 3 clk after its edge.
REQ-036 SHALL cover, max_val=9, wrap, up from 9 -> count 0 and one-cycle tc; down from 0 -> count 9 and tc.
REQ-037 SHALL cover, max_val=9, saturate: up at 9 -> hold 9 with tc; down at 0 -> hold 0 with tc.
REQ-038 SHALL cover load with in=0x50, max_val=0x40 -> count 0x40; load and clk_in edges detected in the same cycle -> loaded value only, no increment.
REQ-039 SHALL cover enable=0 with 5 clk_in pulses -> count unchanged; enable raised while clk_in high -> no event.
REQ-040 SHALL cover rst pulse 1 cycle after a clk_in edge -> count 0, no increment after release.
